// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline hazard controller and the pipeline register wrappers.
// Holds the FSM encoding, the zero-register index and the bubble (flush) convention.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        ERROR    = 2'b10
    } hz_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Control fields carried by a pipeline register; a flush clears only these, data fields pass through.
    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic       branch_eq_ne;
        logic       alu_src;
        logic       reg_dst;
        logic [1:0] alu_op;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t BUBBLE_CTRL = '0;

    function automatic pipe_ctrl_t apply_flush(input pipe_ctrl_t ctrl, input logic flush);
        return flush ? BUBBLE_CTRL : ctrl;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the stall and flush statistics.
// Holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and stall sequencer driving PC and pipeline register enables/flushes.
// Handles data-memory waits (with timeout), taken branches, load-use hazards and jumps.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   RUN      | normal issue; branch / load-use / jump resolved per cycle
//   MEM_WAIT | data memory busy; front of pipe frozen, MEM/WB bubbled
//   ERROR    | memory timeout; everything frozen until reset
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             id_jump,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             mem_branch_taken,
    input  logic             mem_access,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             mem_wb_flush,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int                WAIT_W   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);

    hz_state_t         state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;
    logic              load_use, mem_hold, run_eval, flush_inc, stall_inc;
    logic [4:0]        en_c;
    logic [3:0]        flush_c;

    assign load_use = ex_mem_read && (ex_rt != REG_ZERO) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    // en_c = {pc, if_id, id_ex, ex_mem, mem_wb}; flush_c = {if_id, id_ex, ex_mem, mem_wb}
    always_comb begin
        en_c      = 5'b11111;
        flush_c   = 4'b0000;
        state_nxt = state;
        wait_nxt  = wait_cnt;
        mem_hold  = 1'b0;
        run_eval  = 1'b0;
        flush_inc = 1'b0;
        case (state)
            RUN: begin
                if (mem_access && !mem_ready) begin
                    mem_hold  = 1'b1;
                    state_nxt = MEM_WAIT;
                    wait_nxt  = WAIT_ONE;
                end else begin
                    run_eval = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    run_eval  = 1'b1;
                    state_nxt = RUN;
                    wait_nxt  = '0;
                end else begin
                    mem_hold = 1'b1;
                    if (wait_cnt == WAIT_MAX) begin
                        state_nxt = ERROR;
                    end else begin
                        wait_nxt = wait_cnt + WAIT_ONE;
                    end
                end
            end
            default: begin
                en_c = 5'b00000;
            end
        endcase

        if (mem_hold) begin
            en_c    = 5'b00001;
            flush_c = 4'b0001;
        end else if (run_eval) begin
            if (mem_branch_taken) begin
                flush_c   = 4'b1110;
                flush_inc = 1'b1;
            end else if (load_use) begin
                en_c    = 5'b00111;
                flush_c = 4'b0100;
            end else if (id_jump) begin
                flush_c   = 4'b1000;
                flush_inc = 1'b1;
            end
        end
    end

    assign stall_inc = !en_c[4] && (state != ERROR);

    assign {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = reset ? 5'b00000 : en_c;
    assign {if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush} = reset ? 4'b0000 : flush_c;
    assign mem_error = (state == ERROR);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .count (stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_inc),
        .count (flush_count)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl (CNT_W=3, MEM_TIMEOUT=4).
// Expected outputs come from a small cycle model and are queued, then popped against the DUT.
module tb_pipeline_hazard_ctrl;

    localparam int CW  = 3;
    localparam int TO  = 4;
    localparam int SAT = 7;

    logic          clk = 1'b0;
    logic          reset;
    logic [4:0]    id_rs, id_rt, ex_rt;
    logic          id_uses_rt, id_jump, ex_mem_read, mem_branch_taken, mem_access, mem_ready;
    logic          pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic          if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
    logic          mem_error;
    logic [CW-1:0] stall_count, flush_count;

    typedef struct packed {
        logic [8:0] ctl;
        logic       err;
        logic [7:0] sc;
        logic [7:0] fc;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   ms = 0, mw = 0, msc = 0, mfc = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.CNT_W(CW), .MEM_TIMEOUT(TO)) dut (
        .clk              (clk),
        .reset            (reset),
        .id_rs            (id_rs),
        .id_rt            (id_rt),
        .id_uses_rt       (id_uses_rt),
        .id_jump          (id_jump),
        .ex_mem_read      (ex_mem_read),
        .ex_rt            (ex_rt),
        .mem_branch_taken (mem_branch_taken),
        .mem_access       (mem_access),
        .mem_ready        (mem_ready),
        .pc_en            (pc_en),
        .if_id_en         (if_id_en),
        .id_ex_en         (id_ex_en),
        .ex_mem_en        (ex_mem_en),
        .mem_wb_en        (mem_wb_en),
        .if_id_flush      (if_id_flush),
        .id_ex_flush      (id_ex_flush),
        .ex_mem_flush     (ex_mem_flush),
        .mem_wb_flush     (mem_wb_flush),
        .mem_error        (mem_error),
        .stall_count      (stall_count),
        .flush_count      (flush_count)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] ctl_now();
        return {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};
    endfunction

    task automatic drive(input logic ma, input logic mr, input logic mbt, input logic emr,
                         input logic [4:0] ert, input logic [4:0] irs, input logic [4:0] irt,
                         input logic iur, input logic ij);
        mem_access = ma; mem_ready = mr; mem_branch_taken = mbt; ex_mem_read = emr;
        ex_rt = ert; id_rs = irs; id_rt = irt; id_uses_rt = iur; id_jump = ij;
    endtask

    // One clock cycle: drive at negedge, model pushes expectation, DUT sampled and popped before posedge.
    task automatic cyc(input logic ma, input logic mr, input logic mbt, input logic emr,
                       input logic [4:0] ert, input logic [4:0] irs, input logic [4:0] irt,
                       input logic iur, input logic ij, input string tag);
        exp_t e, g;
        logic lu, hold, run_ok, finc;
        int   ns, nw;
        @(negedge clk);
        drive(ma, mr, mbt, emr, ert, irs, irt, iur, ij);
        #1;
        lu = emr && (ert != 5'd0) && ((ert == irs) || (iur && (ert == irt)));
        hold = 1'b0; run_ok = 1'b0; ns = ms; nw = mw;
        if (ms == 0) begin
            if (ma && !mr) begin hold = 1'b1; ns = 1; nw = 1; end
            else run_ok = 1'b1;
        end else if (ms == 1) begin
            if (mr) begin run_ok = 1'b1; ns = 0; nw = 0; end
            else begin
                hold = 1'b1;
                if (mw == TO) ns = 2;
                else nw = mw + 1;
            end
        end
        if (ms == 2)       e.ctl = 9'b00000_0000;
        else if (hold)     e.ctl = 9'b00001_0001;
        else if (mbt)      e.ctl = 9'b11111_1110;
        else if (lu)       e.ctl = 9'b00111_0100;
        else if (ij)       e.ctl = 9'b11111_1000;
        else               e.ctl = 9'b11111_0000;
        finc  = run_ok && (mbt || (!lu && ij));
        e.err = (ms == 2);
        e.sc  = 8'(msc);
        e.fc  = 8'(mfc);
        sb_q.push_back(e);
        #1;
        g = sb_q.pop_front();
        check_val({tag, "_ctl"}, 32'(ctl_now()), 32'(g.ctl));
        check_val({tag, "_err"}, 32'(mem_error), 32'(g.err));
        check_val({tag, "_stall_cnt"}, 32'(stall_count), 32'(g.sc));
        check_val({tag, "_flush_cnt"}, 32'(flush_count), 32'(g.fc));
        if ((ms != 2) && !e.ctl[8]) msc = (msc < SAT) ? msc + 1 : SAT;
        if (finc) mfc = (mfc < SAT) ? mfc + 1 : SAT;
        ms = ns;
        mw = nw;
    endtask

    task automatic idle(input string tag);
        cyc(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        drive(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        reset = 1'b1;
        #2;
        check_val({tag, "_ctl"}, 32'(ctl_now()), 32'd0);
        check_val({tag, "_err"}, 32'(mem_error), 32'd0);
        check_val({tag, "_cnts"}, 32'({stall_count, flush_count}), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        ms = 0; mw = 0; msc = 0; mfc = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        do_reset("reset");
        idle("idle0");

        cyc(0, 0, 0, 1, 5'd8, 5'd8, 5'd0, 0, 0, "lu_rs");
        idle("lu_after");
        check_val("lu_stall_one", 32'(stall_count), 32'd1);
        cyc(0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 0, 0, "lu_r0");
        cyc(0, 0, 0, 1, 5'd5, 5'd3, 5'd5, 1, 0, "lu_rt");
        cyc(0, 0, 0, 1, 5'd5, 5'd3, 5'd5, 0, 0, "lu_rt_unused");

        cyc(0, 0, 1, 1, 5'd8, 5'd8, 5'd0, 0, 1, "br_lu_j");
        idle("br_after");
        check_val("br_flush_once", 32'(flush_count), 32'd1);
        check_val("br_no_stall", 32'(stall_count), 32'd2);
        cyc(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, "jump");

        cyc(1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, "mem_fast");
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, "mem_wait");
        cyc(1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, "mem_done");
        idle("mem_after");
        check_val("mem_stall_cnt", 32'(stall_count), 32'd5);

        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, "jump_sat");
        idle("sat_after");
        check_val("flush_sat", 32'(flush_count), 32'd7);

        for (int i = 0; i <= TO; i++) cyc(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, "to_wait");
        cyc(0, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 1, "to_err");
        cyc(1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, "to_err_ready");
        check_val("to_sticky", 32'(mem_error), 32'd1);
        check_val("to_frozen", 32'(ctl_now()), 32'd0);
        do_reset("to_reset");
        idle("to_cleared");

        cyc(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, "mid_enter");
        cyc(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, "mid_wait");
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check_val("async_rst_ctl", 32'(ctl_now()), 32'd0);
        check_val("async_rst_stall", 32'(stall_count), 32'd0);
        check_val("async_rst_err", 32'(mem_error), 32'd0);
        @(negedge clk);
        drive(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        reset = 1'b0;
        ms = 0; mw = 0; msc = 0; mfc = 0;
        #2;
        check_val("post_rst_run", 32'(ctl_now()), 32'(9'b11111_0000));
        idle("post_rst_idle");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
